// File: rtl/kart_pkg.sv
// Shared kart definitions: motion commands from the direction decoder, H-bridge pin codes,
// wheel direction and motor channel FSM states.
package kart_pkg;

  localparam logic [2:0] STOP      = 3'b000;
  localparam logic [2:0] FORWARD   = 3'b001;
  localparam logic [2:0] LEFT      = 3'b010;
  localparam logic [2:0] RIGHT     = 3'b011;
  localparam logic [2:0] BACKWARD  = 3'b101;
  localparam logic [2:0] BACKLEFT  = 3'b110;
  localparam logic [2:0] BACKRIGHT = 3'b111;

  localparam logic [1:0] FWD   = 2'b10;
  localparam logic [1:0] REV   = 2'b01;
  localparam logic [1:0] COAST = 2'b00;
  localparam logic [1:0] BRAKE = 2'b11;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } wheel_dir_t;

  typedef enum logic {
    CH_RUN  = 1'b0,
    CH_DEAD = 1'b1
  } chan_state_t;

  function automatic logic [1:0] dir_pins(input wheel_dir_t dir);
    logic [1:0] pins;
    if (dir == DIR_REV) begin
      pins = REV;
    end else begin
      pins = FWD;
    end
    return pins;
  endfunction

endpackage

// File: rtl/motor_pwm_ctrl_if.sv
// Motion command in, H-bridge direction pins and PWM enables out.
interface motor_pwm_ctrl_if;
  logic [2:0] state;
  logic [1:0] l_in;
  logic [1:0] r_in;
  logic       pwm_l;
  logic       pwm_r;

  modport master (output state, input l_in, input r_in, input pwm_l, input pwm_r);
  modport slave  (input state, output l_in, output r_in, output pwm_l, output pwm_r);
endinterface

// File: rtl/motor_pwm_ctrl_channel.sv
// One wheel: soft-start duty ramp, RUN/DEAD reversal FSM and registered bridge pins / PWM.
// MOTOR_BRAKE_EN selects active brake (11) instead of coast (00) whenever the wheel is idle.
module motor_channel
  import kart_pkg::*;
#(
  parameter int PWM_BITS     = 10,
  parameter int RAMP_STEP    = 8,
  parameter int DEAD_PERIODS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                boundary,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  wheel_dir_t          tgt_dir,
  input  logic [PWM_BITS-1:0] tgt_duty,
  output logic [1:0]          pins,
  output logic                pwm
);

  localparam int DCW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(RAMP_STEP);
  localparam logic [DCW-1:0]      DEAD_LAST = DCW'(DEAD_PERIODS - 1);
`ifdef MOTOR_BRAKE_EN
  localparam logic [1:0] IDLE_PINS = BRAKE;
`else
  localparam logic [1:0] IDLE_PINS = COAST;
`endif

  chan_state_t         state_r, state_s;
  wheel_dir_t          dir_r, dir_s;
  logic [PWM_BITS-1:0] duty_r, duty_s, goal_s;
  logic [DCW-1:0]      dead_cnt_r, dead_cnt_s;
  logic [1:0]          pins_r, pins_s;
  logic                pwm_r;

  // Next channel state, evaluated only on the PWM period boundary
  always_comb begin
    state_s    = state_r;
    dir_s      = dir_r;
    duty_s     = duty_r;
    dead_cnt_s = dead_cnt_r;
    goal_s     = tgt_duty;
    if (boundary) begin
      case (state_r)
        CH_RUN: begin
          // A reversal first ramps to zero; a zero target never reverses
          if ((tgt_duty != '0) && (tgt_dir != dir_r)) begin
            goal_s = '0;
            if (duty_r == '0) begin
              state_s    = CH_DEAD;
              dead_cnt_s = '0;
            end else begin
              state_s = CH_RUN;
            end
          end else begin
            goal_s = tgt_duty;
          end
          if (goal_s > duty_r) begin
            duty_s = ((goal_s - duty_r) > STEP) ? (duty_r + STEP) : goal_s;
          end else begin
            duty_s = ((duty_r - goal_s) > STEP) ? (duty_r - STEP) : goal_s;
          end
        end
        CH_DEAD: begin
          duty_s = '0;
          if (dead_cnt_r == DEAD_LAST) begin
            state_s    = CH_RUN;
            dead_cnt_s = '0;
            dir_s      = (tgt_duty != '0) ? tgt_dir : dir_r;
          end else begin
            dead_cnt_s = dead_cnt_r + DCW'(1);
          end
        end
        default: begin
          state_s = CH_RUN;
          duty_s  = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Bridge pins follow the present duty/state; idle whenever no drive is applied
  always_comb begin
    pins_s = IDLE_PINS;
    if ((state_r == CH_RUN) && (duty_r != '0)) begin
      pins_s = dir_pins(dir_r);
    end else begin
      pins_s = IDLE_PINS;
    end
  end

  // Channel state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= CH_RUN;
      dir_r      <= DIR_FWD;
      duty_r     <= '0;
      dead_cnt_r <= '0;
      pins_r     <= COAST;
      pwm_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      dir_r      <= dir_s;
      duty_r     <= duty_s;
      dead_cnt_r <= dead_cnt_s;
      pins_r     <= pins_s;
      pwm_r      <= (pwm_cnt < duty_r);
    end
  end

  assign pins = pins_r;
  assign pwm  = pwm_r;

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Two-wheel H-bridge driver: command synchronizer, command decoder and shared PWM counter
// feeding two motor_channel instances. MOTOR_BRAKE_EN selects brake instead of coast when idle.
module motor_pwm_ctrl
  import kart_pkg::*;
#(
  parameter int PWM_BITS     = 10,
  parameter int DUTY_FULL    = 700,
  parameter int DUTY_INNER   = 300,
  parameter int RAMP_STEP    = 8,
  parameter int DEAD_PERIODS = 4
) (
  input logic             clk,
  input logic             reset,
  motor_pwm_ctrl_if.slave bus
);

  if ((DUTY_FULL < 0) || (DUTY_FULL >= (1 << PWM_BITS))) begin : g_bad_full
    $error("DUTY_FULL out of range for PWM_BITS");
  end
  if ((DUTY_INNER < 0) || (DUTY_INNER >= (1 << PWM_BITS))) begin : g_bad_inner
    $error("DUTY_INNER out of range for PWM_BITS");
  end
  if ((RAMP_STEP < 1) || (RAMP_STEP >= (1 << PWM_BITS))) begin : g_bad_step
    $error("RAMP_STEP out of range for PWM_BITS");
  end
  if (DEAD_PERIODS < 1) begin : g_bad_dead
    $error("DEAD_PERIODS must be at least 1");
  end

  localparam logic [PWM_BITS-1:0] FULL_DUTY  = PWM_BITS'(DUTY_FULL);
  localparam logic [PWM_BITS-1:0] INNER_DUTY = PWM_BITS'(DUTY_INNER);

  logic [2:0]          sync1_r, sync2_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic                boundary_s;
  wheel_dir_t          l_dir_s, r_dir_s;
  logic [PWM_BITS-1:0] l_duty_s, r_duty_s;
  logic [1:0]          l_pins_s, r_pins_s;
  logic                l_pwm_s, r_pwm_s;

  // Command crosses from the decoder's divided clock; two-flop synchronizer plus PWM counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r   <= 3'b000;
      sync2_r   <= 3'b000;
      pwm_cnt_r <= '0;
    end else begin
      sync1_r   <= bus.state;
      sync2_r   <= sync1_r;
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
    end
  end

  assign boundary_s = &pwm_cnt_r;

  // Motion command to per-wheel target direction and duty
  always_comb begin
    l_dir_s  = DIR_FWD;
    r_dir_s  = DIR_FWD;
    l_duty_s = '0;
    r_duty_s = '0;
    case (sync2_r)
      FORWARD: begin
        l_duty_s = FULL_DUTY;
        r_duty_s = FULL_DUTY;
      end
      BACKWARD: begin
        l_dir_s  = DIR_REV;
        r_dir_s  = DIR_REV;
        l_duty_s = FULL_DUTY;
        r_duty_s = FULL_DUTY;
      end
      LEFT: begin
        l_duty_s = INNER_DUTY;
        r_duty_s = FULL_DUTY;
      end
      RIGHT: begin
        l_duty_s = FULL_DUTY;
        r_duty_s = INNER_DUTY;
      end
      BACKLEFT: begin
        l_dir_s  = DIR_REV;
        r_dir_s  = DIR_REV;
        l_duty_s = INNER_DUTY;
        r_duty_s = FULL_DUTY;
      end
      BACKRIGHT: begin
        l_dir_s  = DIR_REV;
        r_dir_s  = DIR_REV;
        l_duty_s = FULL_DUTY;
        r_duty_s = INNER_DUTY;
      end
      default: begin
        l_duty_s = '0;
        r_duty_s = '0;
      end
    endcase
  end

  motor_channel #(
    .PWM_BITS    (PWM_BITS),
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_left (
    .clk     (clk),
    .reset   (reset),
    .boundary(boundary_s),
    .pwm_cnt (pwm_cnt_r),
    .tgt_dir (l_dir_s),
    .tgt_duty(l_duty_s),
    .pins    (l_pins_s),
    .pwm     (l_pwm_s)
  );

  motor_channel #(
    .PWM_BITS    (PWM_BITS),
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_right (
    .clk     (clk),
    .reset   (reset),
    .boundary(boundary_s),
    .pwm_cnt (pwm_cnt_r),
    .tgt_dir (r_dir_s),
    .tgt_duty(r_duty_s),
    .pins    (r_pins_s),
    .pwm     (r_pwm_s)
  );

  assign bus.l_in  = l_pins_s;
  assign bus.r_in  = r_pins_s;
  assign bus.pwm_l = l_pwm_s;
  assign bus.pwm_r = r_pwm_s;

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Scoreboard bench for motor_pwm_ctrl with a 64-cycle PWM period: the stimulus queues the
// expected per-period high time and pins, a monitor measures each period and compares.
module tb_motor_pwm_ctrl;
  import kart_pkg::*;

  localparam int PB     = 6;
  localparam int PERIOD = 1 << PB;
  localparam int FULL   = 40;
  localparam int INNER  = 16;
  localparam int STEP   = 8;
  localparam int DEADP  = 2;
`ifdef MOTOR_BRAKE_EN
  localparam logic [1:0] PI = 2'b11;
`else
  localparam logic [1:0] PI = 2'b00;
`endif
  localparam logic [1:0] PF = 2'b10;
  localparam logic [1:0] PR = 2'b01;

  typedef struct packed {
    logic [7:0] dl;
    logic [7:0] dr;
    logic [1:0] pl;
    logic [1:0] pr;
  } exp_t;

  exp_t exp_q[$];
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tb_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  // Hand-computed per-period duties (step 8, full 40, inner 16, two dead periods)
  int         up_tbl[6]   = '{8, 16, 24, 32, 40, 40};
  int         lt_tbl[4]   = '{32, 24, 16, 16};
  int         back_tbl[3] = '{24, 32, 40};
  int         rev_d[14]   = '{32, 24, 16, 8, 0, 0, 0, 0, 8, 16, 24, 32, 40, 40};
  logic [1:0] rev_p[14]   = '{PF, PF, PF, PF, PI, PI, PI, PI, PR, PR, PR, PR, PR, PR};
  int         stop_d[6]   = '{32, 24, 16, 8, 0, 0};
  logic [1:0] stop_p[6]   = '{PR, PR, PR, PR, PI, PI};

  motor_pwm_ctrl_if bus ();

  motor_pwm_ctrl #(
    .PWM_BITS    (PB),
    .DUTY_FULL   (FULL),
    .DUTY_INNER  (INNER),
    .RAMP_STEP   (STEP),
    .DEAD_PERIODS(DEADP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt + 1) % PERIOD;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Waits for the start of a measurement window, issues a command, queues this window's result
  task automatic run_period(input logic [2:0] cmd, input int dl, input int dr,
                            input logic [1:0] pl, input logic [1:0] pr);
    exp_t e;
    do @(negedge clk); while (reset || tb_cnt != 1);
    bus.state = cmd;
    e.dl = 8'(dl);
    e.dr = 8'(dr);
    e.pl = pl;
    e.pr = pr;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    int         hl, hr;
    logic [1:0] lp, rp;
    bit         take, aborted;
    forever begin
      @(negedge clk);
      if (!reset && tb_cnt == 1) begin
        hl = int'(bus.pwm_l);
        hr = int'(bus.pwm_r);
        #1;
        take    = (exp_q.size() > 0);
        aborted = 1'b0;
        for (int i = 1; i < PERIOD; i++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          hl += int'(bus.pwm_l);
          hr += int'(bus.pwm_r);
        end
        lp = bus.l_in;
        rp = bus.r_in;
        if (take && !aborted) begin
          e = exp_q.pop_front();
          check("high_l", hl, int'(e.dl));
          check("high_r", hr, int'(e.dr));
          check("pins_l", int'(lp), int'(e.pl));
          check("pins_r", int'(rp), int'(e.pr));
        end
      end
    end
  end

  initial begin : adjacency
    logic [1:0] pl, pr;
    pl = 2'b00;
    pr = 2'b00;
    forever begin
      @(negedge clk);
      if (bus.l_in != pl) begin
        check("l_no_flip", int'((pl == PF && bus.l_in == PR) || (pl == PR && bus.l_in == PF)), 0);
        pl = bus.l_in;
      end
      if (bus.r_in != pr) begin
        check("r_no_flip", int'((pr == PF && bus.r_in == PR) || (pr == PR && bus.r_in == PF)), 0);
        pr = bus.r_in;
      end
    end
  end

  initial begin : stimulus
    int n;
    bus.state = STOP;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_l_in", int'(bus.l_in), 0);
    check("rst_r_in", int'(bus.r_in), 0);
    check("rst_pwm_l", int'(bus.pwm_l), 0);
    check("rst_pwm_r", int'(bus.pwm_r), 0);
    reset = 1'b0;

    // Soft start to full forward
    run_period(FORWARD, 0, 0, PI, PI);
    foreach (up_tbl[k]) run_period(FORWARD, up_tbl[k], up_tbl[k], PF, PF);

    // Left turn: inner wheel ramps down, then back to straight
    run_period(LEFT, FULL, FULL, PF, PF);
    foreach (lt_tbl[k]) run_period(LEFT, lt_tbl[k], FULL, PF, PF);
    run_period(FORWARD, INNER, FULL, PF, PF);
    foreach (back_tbl[k]) run_period(FORWARD, back_tbl[k], FULL, PF, PF);

    // Reversal: ramp down, idle through dead time, ramp up in reverse
    run_period(BACKWARD, FULL, FULL, PF, PF);
    foreach (rev_d[k]) run_period(BACKWARD, rev_d[k], rev_d[k], rev_p[k], rev_p[k]);

    // Stop keeps reverse direction; resuming reverse has no dead time
    run_period(STOP, FULL, FULL, PR, PR);
    foreach (stop_d[k]) run_period(STOP, stop_d[k], stop_d[k], stop_p[k], stop_p[k]);
    run_period(BACKWARD, 0, 0, PI, PI);
    run_period(BACKWARD, 8, 8, PR, PR);
    run_period(3'b100, 16, 16, PR, PR);
    run_period(3'b100, 8, 8, PR, PR);
    run_period(3'b100, 0, 0, PI, PI);
    run_period(FORWARD, 0, 0, PI, PI);

    // Now in dead time toward forward; reset in the middle of it
    do @(negedge clk); while (tb_cnt != 1);
    repeat (10) @(negedge clk);
    check("dead_state", int'(dut.u_left.state_r), int'(CH_DEAD));
    check("dead_pins_l", int'(bus.l_in), int'(PI));
    check("dead_pwm_l", int'(bus.pwm_l), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rstdead_l_in", int'(bus.l_in), 0);
    check("rstdead_r_in", int'(bus.r_in), 0);
    check("rstdead_pwm_l", int'(bus.pwm_l), 0);
    check("rstdead_pwm_r", int'(bus.pwm_r), 0);
    check("rstdead_fsm_l", int'(dut.u_left.state_r), int'(CH_RUN));
    check("rstdead_fsm_r", int'(dut.u_right.state_r), int'(CH_RUN));
    bus.state = FORWARD;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Direction back to forward after reset: ramps with no dead time
    run_period(FORWARD, 0, 0, PI, PI);
    run_period(FORWARD, 8, 8, PF, PF);
    run_period(FORWARD, 16, 16, PF, PF);

    n = 0;
    while (exp_q.size() != 0 && n < 4 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
